// File: rtl/overflow_range_store_pkg.sv
// Shared types and defaults for the overflow range store.
// Entry addresses are held zero-extended to ADDR_W so any AW up to 64 shares one compare type.
package overflow_range_store_pkg;

  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned AW_DEFAULT    = 32;
  localparam int unsigned ADDR_W        = 64;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] last;
  } range_entry_t;

endpackage

// File: rtl/overflow_range_store_range_match.sv
// Single-entry containment test: valid && first <= addr <= last, unsigned.
// Purely combinational, zero latency, no flow control.
module range_match
  import overflow_range_store_pkg::*;
(
  input  range_entry_t      ent,
  input  logic [ADDR_W-1:0] addr,
  output logic              match
);

  assign match = ent.valid && (ent.first <= addr) && (addr <= ent.last);

endmodule

// File: rtl/overflow_range_store.sv
// Circular store of address ranges with combinational newest-first lookup; writes take effect next cycle.
// No back-pressure: every cycle may write; when full the oldest entry is overwritten and evict_o pulses.
module overflow_range_store
  import overflow_range_store_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_first_i,
  input  logic [AW-1:0]          wr_last_i,
  input  logic [AW-1:0]          find_addr_i,
  output logic                   hit_o,
  output logic [AW-1:0]          hit_first_o,
  output logic [AW-1:0]          hit_last_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   evict_o,
  output logic                   wr_err_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    first_q [DEPTH];
  logic [AW-1:0]    last_q  [DEPTH];
  logic [PW-1:0]    wp_q;
  logic [PW:0]      count_q;
  logic             evict_q;
  logic             wr_err_q;

  range_entry_t      ent [DEPTH];
  logic [DEPTH-1:0]  match;
  logic [ADDR_W-1:0] find_ext;
  logic [ADDR_W-1:0] wr_first_ext;
  logic [ADDR_W-1:0] wr_last_ext;
  logic              dup;
  logic              inverted;
  logic              accept;
  logic              full;

  assign find_ext     = ADDR_W'(find_addr_i);
  assign wr_first_ext = ADDR_W'(wr_first_i);
  assign wr_last_ext  = ADDR_W'(wr_last_i);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent[i].valid = valid_q[i];
      ent[i].first = ADDR_W'(first_q[i]);
      ent[i].last  = ADDR_W'(last_q[i]);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    range_match u_match (
      .ent   (ent[g]),
      .addr  (find_ext),
      .match (match[g])
    );
  end

  // Walk from oldest (wp) to newest (wp-1) so the most recent match overrides.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    hit_o       = 1'b0;
    hit_first_o = '0;
    hit_last_o  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wp_q - PW'(k);
      if (match[idx]) begin
        hit_o       = 1'b1;
        hit_first_o = ent[idx].first[AW-1:0];
        hit_last_o  = ent[idx].last[AW-1:0];
      end
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent[i].valid && (ent[i].first == wr_first_ext) && (ent[i].last == wr_last_ext)) begin
        dup = 1'b1;
      end
    end
  end

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign inverted = (wr_first_i > wr_last_i);
  assign accept   = wr_en_i && !clear_i && !inverted && !dup;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      wp_q     <= '0;
      count_q  <= '0;
      evict_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      evict_q  <= accept && full;
      wr_err_q <= wr_en_i && !clear_i && inverted;
      if (clear_i) begin
        valid_q <= '0;
        wp_q    <= '0;
        count_q <= '0;
      end else if (accept) begin
        valid_q[wp_q] <= 1'b1;
        wp_q          <= wp_q + 1'b1;
        if (!full) begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  // Address fields are qualified by valid_q, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      first_q[wp_q] <= wr_first_i;
      last_q[wp_q]  <= wr_last_i;
    end
  end

  assign count_o  = count_q;
  assign full_o   = full;
  assign evict_o  = evict_q;
  assign wr_err_o = wr_err_q;

endmodule

// File: tb/tb_overflow_range_store.sv
// Directed checks of the range store at DEPTH=8, AW=32 with hand-computed expectations.
module tb_overflow_range_store;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        wr_en_i;
  logic [31:0] wr_first_i;
  logic [31:0] wr_last_i;
  logic [31:0] find_addr_i;
  logic        hit_o;
  logic [31:0] hit_first_o;
  logic [31:0] hit_last_o;
  logic [3:0]  count_o;
  logic        full_o;
  logic        evict_o;
  logic        wr_err_o;

  int tests = 0;
  int fails = 0;

  overflow_range_store #(.DEPTH(8), .AW(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .wr_en_i     (wr_en_i),
    .wr_first_i  (wr_first_i),
    .wr_last_i   (wr_last_i),
    .find_addr_i (find_addr_i),
    .hit_o       (hit_o),
    .hit_first_o (hit_first_o),
    .hit_last_o  (hit_last_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .evict_o     (evict_o),
    .wr_err_o    (wr_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] f, input logic [31:0] l);
    wr_en_i    = 1'b1;
    wr_first_i = f;
    wr_last_i  = l;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic clr();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic look(input logic [31:0] a);
    find_addr_i = a;
    #1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    wr_en_i     = 1'b0;
    wr_first_i  = '0;
    wr_last_i   = '0;
    find_addr_i = '0;
    #2;
    chk("rst_count",  32'(count_o), 0);
    chk("rst_full",   32'(full_o), 0);
    chk("rst_evict",  32'(evict_o), 0);
    chk("rst_wr_err", 32'(wr_err_o), 0);
    chk("rst_hit",    32'(hit_o), 0);
    chk("rst_hfirst", hit_first_o, 0);
    chk("rst_hlast",  hit_last_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Basic write then lookup
    wr(32'h8000_0100, 32'h8000_0140);
    look(32'h8000_0120);
    chk("basic_hit",    32'(hit_o), 1);
    chk("basic_hfirst", hit_first_o, 32'h8000_0100);
    chk("basic_hlast",  hit_last_o, 32'h8000_0140);
    chk("basic_count",  32'(count_o), 1);
    look(32'h8000_0141);
    chk("basic_miss_above", 32'(hit_o), 0);
    chk("basic_miss_first", hit_first_o, 0);
    look(32'h8000_0100);
    chk("basic_edge_lo", 32'(hit_o), 1);
    clr();
    chk("clr_count", 32'(count_o), 0);

    // Fill past DEPTH: nine distinct writes
    for (int i = 1; i <= 8; i++) begin
      wr(32'h100 * i, 32'h100 * i + 32'h10);
      chk("fill_no_evict", 32'(evict_o), 0);
    end
    chk("fill_count8", 32'(count_o), 8);
    chk("fill_full",   32'(full_o), 1);
    wr_en_i    = 1'b1;
    wr_first_i = 32'h900;
    wr_last_i  = 32'h910;
    look(32'h905);
    chk("same_cycle_prewrite", 32'(hit_o), 0);
    tick();
    wr_en_i = 1'b0;
    chk("ninth_evict", 32'(evict_o), 1);
    chk("ninth_count", 32'(count_o), 8);
    tick();
    chk("evict_one_cycle", 32'(evict_o), 0);
    look(32'h105);
    chk("evicted_oldest", 32'(hit_o), 0);
    look(32'h905);
    chk("newest_hit",    32'(hit_o), 1);
    chk("newest_hfirst", hit_first_o, 32'h900);
    look(32'h205);
    chk("second_kept", 32'(hit_o), 1);

    // Overlap: newest entry wins, ages out in write order
    clr();
    wr(32'h1000, 32'h10FF);
    wr(32'h1080, 32'h11FF);
    look(32'h10A0);
    chk("ovl_hfirst", hit_first_o, 32'h1080);
    chk("ovl_hlast",  hit_last_o, 32'h11FF);
    look(32'h1010);
    chk("ovl_older_only", hit_first_o, 32'h1000);
    for (int j = 0; j < 7; j++) wr(32'h4000 + 32'h100 * j, 32'h4010 + 32'h100 * j);
    chk("ovl_evict", 32'(evict_o), 1);
    look(32'h1010);
    chk("ovl_a_gone", 32'(hit_o), 0);
    look(32'h10A0);
    chk("ovl_b_still", hit_first_o, 32'h1080);
    wr(32'h4700, 32'h4710);
    look(32'h10A0);
    chk("ovl_b_gone", 32'(hit_o), 0);

    // Duplicate, inverted, single-byte
    clr();
    wr(32'h2000, 32'h2010);
    wr(32'h2000, 32'h2010);
    chk("dup_count",  32'(count_o), 1);
    chk("dup_no_err", 32'(wr_err_o), 0);
    wr(32'h3010, 32'h3000);
    chk("inv_err",   32'(wr_err_o), 1);
    chk("inv_count", 32'(count_o), 1);
    tick();
    chk("inv_err_one_cycle", 32'(wr_err_o), 0);
    wr(32'h5000, 32'h5000);
    chk("single_count", 32'(count_o), 2);
    look(32'h5000);
    chk("single_hit", 32'(hit_o), 1);
    look(32'h5001);
    chk("single_miss", 32'(hit_o), 0);

    // Clear beats simultaneous write
    clr();
    for (int j = 0; j < 3; j++) wr(32'h6000 + 32'h100 * j, 32'h600F + 32'h100 * j);
    chk("pre_clear_count", 32'(count_o), 3);
    clear_i = 1'b1;
    wr(32'h7000, 32'h70FF);
    clear_i = 1'b0;
    chk("clrwr_count", 32'(count_o), 0);
    chk("clrwr_evict", 32'(evict_o), 0);
    chk("clrwr_err",   32'(wr_err_o), 0);
    for (int j = 0; j < 3; j++) begin
      look(32'h6005 + 32'h100 * j);
      chk("clrwr_old_miss", 32'(hit_o), 0);
    end
    look(32'h7010);
    chk("clrwr_lost_write", 32'(hit_o), 0);
    wr(32'h7000, 32'h70FF);
    chk("post_clear_count", 32'(count_o), 1);
    look(32'h7010);
    chk("post_clear_hit", 32'(hit_o), 1);
    look(32'h6005);
    chk("post_clear_old", 32'(hit_o), 0);

    // Asynchronous reset mid-operation
    clr();
    for (int j = 0; j < 5; j++) wr(32'h8000 + 32'h100 * j, 32'h80FF + 32'h100 * j);
    chk("pre_rst_count", 32'(count_o), 5);
    look(32'h8005);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_count", 32'(count_o), 0);
    chk("async_rst_hit",   32'(hit_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("after_rst_count", 32'(count_o), 0);
    chk("after_rst_hit",   32'(hit_o), 0);
    wr(32'h9000, 32'h90FF);
    look(32'h9050);
    chk("after_rst_wr_hit",    32'(hit_o), 1);
    chk("after_rst_wr_hfirst", hit_first_o, 32'h9000);
    chk("after_rst_wr_count",  32'(count_o), 1);
    look(32'h8005);
    chk("after_rst_old_miss", 32'(hit_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
